// File: rtl/pfpu32_cmp_ctrl.sv
// Sequencing controller for the single-precision FP compare path.
// Registers a compare request, unpacks both operands, compares them and holds the flag result.
module pfpu32_cmp_ctrl #(
  parameter int unsigned OPC_WIDTH     = 3,
  parameter bit          HOLD_ON_STALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic [OPC_WIDTH-1:0] opc_i,
  input  logic                 unordered_i,
  input  logic [31:0]          rfa_i,
  input  logic [31:0]          rfb_i,
  output logic                 cmp_valid_o,
  input  logic                 cmp_taken_i,
  output logic                 cmp_flag_o,
  output logic                 cmp_inv_o,
  output logic                 cmp_inf_o,
  output logic                 except_inv_o,
  input  logic                 except_clr_i
);

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned FRAC_W = 24;
  localparam int unsigned MAG_W  = EXP_W + FRAC_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UNPACK = 2'd1;
  localparam logic [1:0] ST_CMP    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [OPC_WIDTH-1:0] OPC_EQ = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OPC_NE = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_GT = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OPC_GE = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OPC_LT = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OPC_LE = OPC_WIDTH'(5);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp10;
    logic [FRAC_W-1:0] fract;
    logic              inf;
    logic              zero;
    logic              snan;
    logic              qnan;
  } unpk_t;

  // Denormals take exponent 1 with no hidden bit so {exp10, fract} orders by magnitude.
  function automatic unpk_t unpack_op(input logic [31:0] x);
    unpk_t       u;
    logic [7:0]  e;
    logic [22:0] f;
    e       = x[30:23];
    f       = x[22:0];
    u.sign  = x[31];
    u.exp10 = (e == 8'd0) ? EXP_W'(1) : EXP_W'(e);
    u.fract = {(e != 8'd0), f};
    u.inf   = (e == 8'hFF) & (f == 23'd0);
    u.zero  = (e == 8'd0) & (f == 23'd0);
    u.snan  = (e == 8'hFF) & (f != 23'd0) & ~f[22];
    u.qnan  = (e == 8'hFF) & f[22];
    return u;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [OPC_WIDTH-1:0] opc_q, opc_d;
  logic                 unord_q, unord_d;
  logic [31:0]          rfa_q, rfa_d, rfb_q, rfb_d;
  unpk_t                ua_q, ua_d, ub_q, ub_d;
  logic                 valid_q, valid_d, flag_q, flag_d, inv_q, inv_d, inf_q, inf_d;
  logic                 sticky_q, sticky_d;

  logic                 retire, accept;
  logic [MAG_W-1:0]     mag_a, mag_b;
  logic                 nan_any, snan_any, both_zero, aeqb, altb, agtb;
  logic                 flag_raw, rel_op, known_op, flag_c, inv_c, inf_c;

  assign retire  = HOLD_ON_STALL ? cmp_taken_i : 1'b1;
  assign ready_o = (state_q == ST_IDLE) | ((state_q == ST_DONE) & retire);
  assign accept  = start_i & ready_o & ~flush_i;

  // Comparator core: evaluates from the unpacked operand registers.
  always_comb begin : fcmp_core
    mag_a     = {ua_q.exp10, ua_q.fract};
    mag_b     = {ub_q.exp10, ub_q.fract};
    nan_any   = ua_q.snan | ua_q.qnan | ub_q.snan | ub_q.qnan;
    snan_any  = ua_q.snan | ub_q.snan;
    both_zero = ua_q.zero & ub_q.zero;
    aeqb      = both_zero | ((ua_q.sign == ub_q.sign) & (mag_a == mag_b));
    if (ua_q.sign != ub_q.sign) begin
      altb = ua_q.sign & ~both_zero;
    end else if (ua_q.sign) begin
      altb = mag_a > mag_b;
    end else begin
      altb = mag_a < mag_b;
    end
    agtb     = ~altb & ~aeqb;
    flag_raw = 1'b0;
    rel_op   = 1'b0;
    known_op = 1'b1;
    case (opc_q)
      OPC_EQ:  flag_raw = aeqb;
      OPC_NE:  flag_raw = ~aeqb;
      OPC_GT:  begin flag_raw = agtb;        rel_op = 1'b1; end
      OPC_GE:  begin flag_raw = agtb | aeqb; rel_op = 1'b1; end
      OPC_LT:  begin flag_raw = altb;        rel_op = 1'b1; end
      OPC_LE:  begin flag_raw = altb | aeqb; rel_op = 1'b1; end
      default: known_op = 1'b0;
    endcase
    flag_c = known_op & (nan_any ? unord_q : flag_raw);
    inv_c  = known_op & (snan_any | (nan_any & rel_op & ~unord_q));
    inf_c  = ua_q.inf | ub_q.inf;
  end

  // Next-state and datapath register inputs; flush overrides every state.
  always_comb begin : next_state
    state_d  = state_q;
    opc_d    = opc_q;
    unord_d  = unord_q;
    rfa_d    = rfa_q;
    rfb_d    = rfb_q;
    ua_d     = ua_q;
    ub_d     = ub_q;
    valid_d  = valid_q;
    flag_d   = flag_q;
    inv_d    = inv_q;
    inf_d    = inf_q;
    sticky_d = sticky_q & ~except_clr_i;
    if (accept) begin
      opc_d   = opc_i;
      unord_d = unordered_i;
      rfa_d   = rfa_i;
      rfb_d   = rfb_i;
    end
    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_UNPACK;
        ST_UNPACK: begin
          ua_d    = unpack_op(rfa_q);
          ub_d    = unpack_op(rfb_q);
          state_d = ST_CMP;
        end
        ST_CMP: begin
          flag_d  = flag_c;
          inv_d   = inv_c;
          inf_d   = inf_c;
          valid_d = 1'b1;
          if (inv_c) sticky_d = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (retire) begin
            valid_d = 1'b0;
            state_d = accept ? ST_UNPACK : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin : ctrl_reg
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      flag_q   <= 1'b0;
      inv_q    <= 1'b0;
      inf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      flag_q   <= flag_d;
      inv_q    <= inv_d;
      inf_q    <= inf_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin : data_reg
    opc_q   <= opc_d;
    unord_q <= unord_d;
    rfa_q   <= rfa_d;
    rfb_q   <= rfb_d;
    ua_q    <= ua_d;
    ub_q    <= ub_d;
  end

  assign cmp_valid_o  = valid_q;
  assign cmp_flag_o   = flag_q;
  assign cmp_inv_o    = inv_q;
  assign cmp_inf_o    = inf_q;
  assign except_inv_o = sticky_q;

endmodule

// File: tb/tb_pfpu32_cmp_ctrl.sv
// Bench for pfpu32_cmp_ctrl: compare vector table through a result scoreboard,
// plus hand-written latency, stall, flush, sticky-flag and reset sequences.
module tb_pfpu32_cmp_ctrl;

  logic        clk, rst, flush_i, start_i, ready_o, unordered_i;
  logic [2:0]  opc_i;
  logic [31:0] rfa_i, rfb_i;
  logic        cmp_valid_o, cmp_taken_i, cmp_flag_o, cmp_inv_o, cmp_inf_o;
  logic        except_inv_o, except_clr_i;

  pfpu32_cmp_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .start_i      (start_i),
    .ready_o      (ready_o),
    .opc_i        (opc_i),
    .unordered_i  (unordered_i),
    .rfa_i        (rfa_i),
    .rfb_i        (rfb_i),
    .cmp_valid_o  (cmp_valid_o),
    .cmp_taken_i  (cmp_taken_i),
    .cmp_flag_o   (cmp_flag_o),
    .cmp_inv_o    (cmp_inv_o),
    .cmp_inf_o    (cmp_inf_o),
    .except_inv_o (except_inv_o),
    .except_clr_i (except_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {flag, inv, inf}
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opc;
    logic        unord;
    logic [2:0]  exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  vec_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  bit   acc_ev, ret_ev;

  function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] opc, input logic unord, input logic [2:0] exp);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.opc = opc; v.unord = unord; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cur = v; rfa_i = v.a; rfb_i = v.b; opc_i = v.opc; unordered_i = v.unord;
  endtask

  // Samples pre-edge values, updates the scoreboard, then advances to the next negedge.
  task automatic cycle();
    vec_t v;
    #1;
    if (rst || flush_i) sb_q.delete();
    acc_ev = !rst && !flush_i && start_i && ready_o;
    ret_ev = !rst && !flush_i && cmp_valid_o && cmp_taken_i;
    if (ret_ev) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_unexpected: result %0b with empty queue", {cmp_flag_o, cmp_inv_o, cmp_inf_o});
      end else begin
        v = sb_q.pop_front();
        chk({"sb_", v.name}, 32'({cmp_flag_o, cmp_inv_o, cmp_inf_o}), 32'(v.exp));
      end
    end
    if (acc_ev) sb_q.push_back(cur);
    @(negedge clk);
  endtask

  task automatic wait_accept(input string nm, output int n);
    n = 0;
    do begin cycle(); n++; end while (!acc_ev && n < 20);
    if (!acc_ev) chk({nm, "_accept_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int   n;
    vec_t v_lt, v_snan;

    rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; cmp_taken_i = 1'b0; except_clr_i = 1'b0;
    rfa_i = '0; rfb_i = '0; opc_i = '0; unordered_i = 1'b0;
    v_lt   = mk("lt_1_2", 32'h3F800000, 32'h40000000, 3'd4, 1'b0, 3'b100);
    v_snan = mk("snan_eq", 32'h7FA00000, 32'h3F800000, 3'd0, 1'b0, 3'b010);
    step_n(3);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(ready_o), 32'(1));
    chk("rst_outs", 32'({cmp_valid_o, cmp_flag_o, cmp_inv_o, cmp_inf_o, except_inv_o}), 32'(0));

    // Latency: valid two edges after accept, not ready in UNPACK/CMP
    drive(v_lt); start_i = 1'b1;
    wait_accept("lat", n);
    start_i = 1'b0;
    chk("unpack_ready", 32'(ready_o), 32'(0));
    chk("unpack_valid", 32'(cmp_valid_o), 32'(0));
    cycle();
    chk("cmp_ready", 32'(ready_o), 32'(0));
    chk("cmp_valid", 32'(cmp_valid_o), 32'(0));
    cycle();
    chk("done_valid", 32'(cmp_valid_o), 32'(1));

    // Stall in DONE: outputs constant, not ready
    for (int i = 0; i < 5; i++) begin
      chk("stall_outs", 32'({cmp_valid_o, cmp_flag_o, cmp_inv_o, cmp_inf_o}), 32'b1100);
      chk("stall_ready", 32'(ready_o), 32'(0));
      cycle();
    end

    // Take and accept on the same edge
    drive(v_snan); start_i = 1'b1; cmp_taken_i = 1'b1;
    #1 chk("take_ready", 32'(ready_o), 32'(1));
    cycle();
    chk("b2b_accept", 32'(acc_ev), 32'(1));
    start_i = 1'b0; cmp_taken_i = 1'b0;
    chk("b2b_valid_clr", 32'(cmp_valid_o), 32'(0));
    cycle();
    chk("b2b_valid_cmp", 32'(cmp_valid_o), 32'(0));
    cycle();
    chk("b2b_valid", 32'(cmp_valid_o), 32'(1));
    chk("snan_sticky", 32'(except_inv_o), 32'(1));
    cmp_taken_i = 1'b1;
    cycle();
    cmp_taken_i = 1'b0;
    chk("retire_valid", 32'(cmp_valid_o), 32'(0));
    chk("sticky_after_retire", 32'(except_inv_o), 32'(1));
    except_clr_i = 1'b1;
    cycle();
    except_clr_i = 1'b0;
    chk("sticky_cleared", 32'(except_inv_o), 32'(0));

    // Flush in UNPACK aborts an sNaN compare
    drive(v_snan); start_i = 1'b1; cmp_taken_i = 1'b1;
    wait_accept("flush", n);
    start_i = 1'b0; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'(1));
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", 32'(cmp_valid_o), 32'(0));
      chk("flush_no_sticky", 32'(except_inv_o), 32'(0));
      cycle();
    end

    // Clear on the same edge as an inv load: set wins
    drive(v_snan); start_i = 1'b1; cmp_taken_i = 1'b0;
    wait_accept("setclr", n);
    start_i = 1'b0;
    cycle();
    except_clr_i = 1'b1;
    cycle();
    except_clr_i = 1'b0;
    chk("setclr_valid", 32'(cmp_valid_o), 32'(1));
    chk("setclr_sticky", 32'(except_inv_o), 32'(1));
    cmp_taken_i = 1'b1;
    cycle();

    // Reset mid-operation discards the request
    drive(v_lt); start_i = 1'b1;
    wait_accept("midrst", n);
    start_i = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_ready", 32'(ready_o), 32'(1));
    chk("midrst_outs", 32'({cmp_valid_o, except_inv_o}), 32'(0));
    cycle();
    chk("midrst_no_valid", 32'(cmp_valid_o), 32'(0));

    // Table: back-to-back requests with taken held high
    tbl.push_back(mk("lt_ord",       32'h3F800000, 32'h40000000, 3'd4, 1'b0, 3'b100));
    tbl.push_back(mk("snan_eq",      32'h7FA00000, 32'h3F800000, 3'd0, 1'b0, 3'b010));
    tbl.push_back(mk("qnan_ult",     32'h7FC00000, 32'h00000000, 3'd4, 1'b1, 3'b100));
    tbl.push_back(mk("qnan_lt",      32'h7FC00000, 32'h00000000, 3'd4, 1'b0, 3'b010));
    tbl.push_back(mk("pz_eq_nz",     32'h00000000, 32'h80000000, 3'd0, 1'b0, 3'b100));
    tbl.push_back(mk("ninf_lt",      32'hFF800000, 32'hC2C80000, 3'd4, 1'b0, 3'b101));
    tbl.push_back(mk("gt_2_1",       32'h40000000, 32'h3F800000, 3'd2, 1'b0, 3'b100));
    tbl.push_back(mk("ge_eq",        32'h3F800000, 32'h3F800000, 3'd3, 1'b0, 3'b100));
    tbl.push_back(mk("ne_eq",        32'h3F800000, 32'h3F800000, 3'd1, 1'b0, 3'b000));
    tbl.push_back(mk("le_neg",       32'hBF800000, 32'h3F800000, 3'd5, 1'b0, 3'b100));
    tbl.push_back(mk("opc6_snan",    32'h7FA00000, 32'h3F800000, 3'd6, 1'b0, 3'b000));
    tbl.push_back(mk("opc7",         32'h3F800000, 32'h40000000, 3'd7, 1'b0, 3'b000));
    tbl.push_back(mk("inf_gt_max",   32'h7F800000, 32'h7F7FFFFF, 3'd2, 1'b0, 3'b101));
    tbl.push_back(mk("denorm_gt_0",  32'h00000001, 32'h00000000, 3'd2, 1'b0, 3'b100));
    tbl.push_back(mk("ndenorm_lt_0", 32'h80000001, 32'h00000000, 3'd4, 1'b0, 3'b100));
    tbl.push_back(mk("qnan_une",     32'h7FC00000, 32'h3F800000, 3'd1, 1'b1, 3'b100));
    tbl.push_back(mk("neg2_lt_neg3", 32'hC0000000, 32'hC0400000, 3'd4, 1'b0, 3'b000));
    tbl.push_back(mk("inf_eq_inf",   32'h7F800000, 32'h7F800000, 3'd0, 1'b0, 3'b101));

    start_i = 1'b1; cmp_taken_i = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      wait_accept(tbl[i].name, n);
      if (i > 0 && acc_ev) chk({"thru_", tbl[i].name}, 32'(n), 32'(3));
    end
    start_i = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin cycle(); n++; end
    chk("sb_drain", 32'(sb_q.size()), 32'(0));
    chk("table_sticky", 32'(except_inv_o), 32'(1));
    chk("end_idle_ready", 32'(ready_o), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
